// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption core: one round per clock through a single
// SubBytes/ShiftRows/MixColumns datapath, with a valid/ready handshake on both sides.

// Byte substitution over every byte of the state using the AES S-box table.
module subBytes #(
   parameter int WIDTH = 8,
   parameter int DIM   = 4
) (
   input  logic [DIM*DIM*WIDTH-1:0] state,
   output logic [DIM*DIM*WIDTH-1:0] result
);

   // Entry x sits at bits [(255-x)*8 +: 8], so the index is simply {~x, 3'b000}.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[{~x, 3'b000} +: 8];
   endfunction

   for (genvar k = 0; k < DIM*DIM; k++) begin : g_byte
      assign result[k*WIDTH +: WIDTH] = sbox(state[k*WIDTH +: WIDTH]);
   end

endmodule

// Row r of the state matrix rotates left by r positions; byte i*DIM+j is column i, row j.
module ShiftRows #(
   parameter int WIDTH = 8,
   parameter int DIM   = 4
) (
   input  logic [DIM*DIM*WIDTH-1:0] state,
   output logic [DIM*DIM*WIDTH-1:0] result
);

   for (genvar c = 0; c < DIM; c++) begin : g_col
      for (genvar r = 0; r < DIM; r++) begin : g_row
         assign result[(c*DIM + r)*WIDTH +: WIDTH] =
            state[(((c + r) % DIM)*DIM + r)*WIDTH +: WIDTH];
      end
   end

endmodule

// Column mixing with the fixed AES polynomial {03}x^3 + {01}x^2 + {01}x + {02}.
module Mix_columns #(
   parameter int WIDTH = 8,
   parameter int DIM   = 4
) (
   input  logic [DIM*DIM*WIDTH-1:0] state,
   output logic [DIM*DIM*WIDTH-1:0] result
);

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   for (genvar c = 0; c < DIM; c++) begin : g_col
      logic [WIDTH-1:0] a0, a1, a2, a3;

      assign a0 = state[(c*DIM + 0)*WIDTH +: WIDTH];
      assign a1 = state[(c*DIM + 1)*WIDTH +: WIDTH];
      assign a2 = state[(c*DIM + 2)*WIDTH +: WIDTH];
      assign a3 = state[(c*DIM + 3)*WIDTH +: WIDTH];

      assign result[(c*DIM + 0)*WIDTH +: WIDTH] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign result[(c*DIM + 1)*WIDTH +: WIDTH] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign result[(c*DIM + 2)*WIDTH +: WIDTH] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign result[(c*DIM + 3)*WIDTH +: WIDTH] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end

endmodule

module aes_round_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIM   = 4,
   parameter int NR    = 10
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [DIM*DIM*WIDTH-1:0] data_i,
   output logic [3:0]               rk_idx_o,
   input  logic [DIM*DIM*WIDTH-1:0] rk_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [DIM*DIM*WIDTH-1:0] data_o,
   output logic                     busy_o
);

   localparam int BW = DIM*DIM*WIDTH;
   localparam logic [3:0] LAST_MID_ROUND = 4'(NR - 1);
   localparam logic [3:0] FINAL_ROUND    = 4'(NR);

   // Three-bit encoding leaves spare codes so a corrupted state has somewhere to recover from.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ROUND = 3'd1,
      FINAL = 3'd2,
      DONE  = 3'd3
   } fsm_t;

   fsm_t          fsm_q, fsm_d;
   logic [3:0]    round_q, round_d;
   logic [BW-1:0] state_q, state_d;

   logic [BW-1:0] sub_out, shift_out, mix_out;

   subBytes #(.WIDTH(WIDTH), .DIM(DIM)) u_sub (
      .state  (state_q),
      .result (sub_out)
   );

   ShiftRows #(.WIDTH(WIDTH), .DIM(DIM)) u_shift (
      .state  (sub_out),
      .result (shift_out)
   );

   Mix_columns #(.WIDTH(WIDTH), .DIM(DIM)) u_mix (
      .state  (shift_out),
      .result (mix_out)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q   <= IDLE;
         round_q <= '0;
         state_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         state_q <= state_d;
      end
   end

   // The key store answers rk_idx_o within the same cycle, so each state names its key here.
   always_comb begin
      fsm_d       = fsm_q;
      round_d     = round_q;
      state_d     = state_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = 1'b1;
      rk_idx_o    = 4'd0;

      case (fsm_q)
         IDLE: begin
            in_ready_o = 1'b1;
            busy_o     = 1'b0;
            if (in_valid_i) begin
               state_d = data_i ^ rk_i;
               round_d = 4'd1;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            rk_idx_o = round_q;
            state_d  = mix_out ^ rk_i;
            round_d  = round_q + 4'd1;
            if (round_q == LAST_MID_ROUND) begin
               fsm_d = FINAL;
            end
         end
         FINAL: begin
            rk_idx_o = FINAL_ROUND;
            state_d  = shift_out ^ rk_i;
            fsm_d    = DONE;
         end
         DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               fsm_d = IDLE;
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   assign data_o = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: known-answer table plus hand-built
// sequences for stalls, back-to-back blocks and mid-operation reset.
module tb_aes_round_ctrl;

   localparam int WIDTH = 8;
   localparam int DIM   = 4;
   localparam int NR    = 10;
   localparam int BW    = DIM*DIM*WIDTH;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [BW-1:0] data_i;
   logic [3:0]    rk_idx_o;
   logic [BW-1:0] rk_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [BW-1:0] data_o;
   logic          busy_o;

   typedef struct {
      logic [BW-1:0] pt;
      logic [BW-1:0] key;
      logic [BW-1:0] exp;
   } vec_t;

   typedef struct {
      logic [BW-1:0] exp;
      int            t_xfer;
   } sb_t;

   sb_t           sb [$];
   vec_t          vecs [5];
   logic [7:0]    sbox_tab [256];
   logic [BW-1:0] round_keys [0:10];
   logic [BW-1:0] cur_exp;
   int            cycle_cnt = 0;
   int            checks    = 0;
   int            errors    = 0;
   bit            prev_ov   = 1'b0;

   aes_round_ctrl #(.WIDTH(WIDTH), .DIM(DIM), .NR(NR)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .data_i      (data_i),
      .rk_idx_o    (rk_idx_o),
      .rk_i        (rk_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .data_o      (data_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cycle_cnt <= cycle_cnt + 1;

   // Combinational key store driven from the schedule of the currently loaded key.
   assign rk_i = (rk_idx_o <= 4'd10) ? round_keys[rk_idx_o] : '0;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a = a_in;
      logic [7:0] b = b_in;
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box derived from the GF(2^8) inverse (x^254) and the affine map.
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
   endfunction

   // Byte j of a word lives at [8j+:8], mirroring the bus layout of the key.
   function automatic logic [BW-1:0] round_key_of(input logic [BW-1:0] key, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t    = sub_word({t[7:0], t[31:8]}) ^ {24'h0, rcon};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
   endfunction

   function automatic logic [BW-1:0] sub_bytes_m(input logic [BW-1:0] s);
      logic [BW-1:0] o;
      for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox_tab[s[8*k +: 8]];
      return o;
   endfunction

   function automatic logic [BW-1:0] shift_rows_m(input logic [BW-1:0] s);
      logic [BW-1:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c + r) +: 8] = s[8*(4*((c + r) % 4) + r) +: 8];
      return o;
   endfunction

   function automatic logic [BW-1:0] mix_columns_m(input logic [BW-1:0] s);
      logic [BW-1:0] o;
      logic [7:0]    a [4];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[8*(4*c + r) +: 8];
         for (int r = 0; r < 4; r++)
            o[8*(4*c + r) +: 8] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03)
                                  ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
      return o;
   endfunction

   function automatic logic [BW-1:0] aes_model(input logic [BW-1:0] pt, input logic [BW-1:0] key);
      logic [BW-1:0] s = pt ^ round_key_of(key, 0);
      for (int r = 1; r < NR; r++) s = mix_columns_m(shift_rows_m(sub_bytes_m(s))) ^ round_key_of(key, r);
      return shift_rows_m(sub_bytes_m(s)) ^ round_key_of(key, NR);
   endfunction

   // FIPS-197 writes byte 0 first (leftmost); the bus puts byte 0 in the low bits.
   function automatic logic [BW-1:0] fips(input logic [BW-1:0] h);
      logic [BW-1:0] v;
      for (int k = 0; k < 16; k++) v[8*k +: 8] = h[8*(15-k) +: 8];
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [BW-1:0] actual, input logic [BW-1:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
      end
   endtask

   task automatic fail_timeout(input string name, input int limit);
      checks++;
      errors++;
      $display("[TB] FAIL %s: no event within %0d cycles, expected one", name, limit);
   endtask

   task automatic load_key(input logic [BW-1:0] key);
      for (int r = 0; r <= NR; r++) round_keys[r] = round_key_of(key, r);
   endtask

   // Offers a block and returns at the falling edge just before the accepting rising edge.
   task automatic applyStimulus(input logic [BW-1:0] pt, input logic [BW-1:0] exp, output int t_xfer);
      data_i     = pt;
      cur_exp    = exp;
      in_valid_i = 1'b1;
      t_xfer     = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk_i);
         if (in_ready_o) begin
            t_xfer = cycle_cnt;
            break;
         end
      end
      if (t_xfer < 0) fail_timeout("input transfer", 40);
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk_i);
         #1;
         if (sb.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) fail_timeout("output drain", 60);
   endtask

   // Scoreboard: push on input handshake, check latency on out_valid rise, pop on output handshake.
   task automatic monitor_loop();
      sb_t e;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            sb.delete();
            prev_ov = 1'b0;
         end else begin
            if (out_valid_o && !prev_ov) begin
               if (sb.size() == 0) fail_timeout("out_valid without a pending block", 0);
               else checkOutput("latency", BW'(cycle_cnt - sb[0].t_xfer), BW'(NR + 1));
            end
            if (out_valid_o && out_ready_i) begin
               if (sb.size() == 0) begin
                  fail_timeout("output transfer without a pending block", 0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("ciphertext", data_o, e.exp);
               end
            end
            if (in_valid_i && in_ready_o) sb.push_back('{cur_exp, cycle_cnt});
            prev_ov = out_valid_o;
         end
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int            t_a, t_b;
      logic [BW-1:0] pt2, exp2;

      for (int x = 0; x < 256; x++) sbox_tab[x] = sbox_calc(8'(x));

      vecs[0] = '{fips(128'h3243f6a8885a308d313198a2e0370734),
                  fips(128'h2b7e151628aed2a6abf7158809cf4f3c),
                  fips(128'h3925841d02dc09fbdc118597196a0b32)};
      vecs[1] = '{'0, '0, fips(128'h66e94bd4ef8a2c3b884cfa59ca342b2e)};
      vecs[2] = '{fips(128'h00112233445566778899aabbccddeeff),
                  fips(128'h000102030405060708090a0b0c0d0e0f),
                  fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a)};
      for (int i = 3; i < 5; i++) begin
         vecs[i].pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
         vecs[i].key = {$urandom(), $urandom(), $urandom(), $urandom()};
         vecs[i].exp = aes_model(vecs[i].pt, vecs[i].key);
      end
      pt2  = fips(128'h00112233445566778899aabbccddeeff);
      exp2 = aes_model(pt2, vecs[0].key);

      fork
         monitor_loop();
      join_none

      rst_i       = 1'b1;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      data_i      = '0;
      cur_exp     = '0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("reset in_ready",  BW'(in_ready_o),  BW'(1));
      checkOutput("reset out_valid", BW'(out_valid_o), BW'(0));
      checkOutput("reset busy",      BW'(busy_o),      BW'(0));
      checkOutput("reset rk_idx",    BW'(rk_idx_o),    BW'(0));
      checkOutput("reset data_o",    data_o,           BW'(0));

      $display("[TB] FIPS-197 block with key index trace and 20-cycle stall");
      @(posedge clk_i);
      #1;
      load_key(vecs[0].key);
      applyStimulus(vecs[0].pt, vecs[0].exp, t_a);
      checkOutput("rk_idx cycle 0", BW'(rk_idx_o), BW'(0));
      for (int k = 1; k <= NR + 1; k++) begin
         @(posedge clk_i);
         #1;
         if (k == 1) in_valid_i = 1'b0;
         @(negedge clk_i);
         checkOutput($sformatf("rk_idx cycle %0d", k), BW'(rk_idx_o), BW'((k <= NR) ? k : 0));
         checkOutput($sformatf("busy cycle %0d", k), BW'(busy_o), BW'(1));
      end
      checkOutput("out_valid at done", BW'(out_valid_o), BW'(1));
      for (int s = 0; s < 20; s++) begin
         @(posedge clk_i);
         #1;
         @(negedge clk_i);
         checkOutput($sformatf("stall out_valid %0d", s), BW'(out_valid_o), BW'(1));
         checkOutput($sformatf("stall data_o %0d", s), data_o, vecs[0].exp);
         checkOutput($sformatf("stall in_ready %0d", s), BW'(in_ready_o), BW'(0));
      end
      @(posedge clk_i);
      #1 out_ready_i = 1'b1;
      @(negedge clk_i);
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      checkOutput("idle after release in_ready",  BW'(in_ready_o),  BW'(1));
      checkOutput("idle after release out_valid", BW'(out_valid_o), BW'(0));
      checkOutput("idle after release busy",      BW'(busy_o),      BW'(0));

      $display("[TB] known-answer and random vector table");
      @(posedge clk_i);
      #1;
      for (int i = 0; i < 5; i++) begin
         load_key(vecs[i].key);
         applyStimulus(vecs[i].pt, vecs[i].exp, t_a);
         @(posedge clk_i);
         #1 in_valid_i = 1'b0;
         wait_drain();
      end

      $display("[TB] back-to-back blocks with in_valid held high");
      load_key(vecs[0].key);
      applyStimulus(vecs[0].pt, vecs[0].exp, t_a);
      @(posedge clk_i);
      #1;
      applyStimulus(pt2, exp2, t_b);
      checkOutput("transfer spacing", BW'(t_b - t_a), BW'(NR + 2));
      @(posedge clk_i);
      #1 in_valid_i = 1'b0;
      wait_drain();

      $display("[TB] reset during round 5");
      load_key(vecs[2].key);
      applyStimulus(vecs[2].pt, vecs[2].exp, t_a);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk_i);
         #1;
         if (k == 1) in_valid_i = 1'b0;
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      checkOutput("rk_idx before abort", BW'(rk_idx_o), BW'(5));
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("abort in_ready",  BW'(in_ready_o),  BW'(1));
      checkOutput("abort busy",      BW'(busy_o),      BW'(0));
      checkOutput("abort out_valid", BW'(out_valid_o), BW'(0));
      checkOutput("abort data_o",    data_o,           BW'(0));
      @(posedge clk_i);
      #1;
      applyStimulus(vecs[2].pt, vecs[2].exp, t_a);
      @(posedge clk_i);
      #1 in_valid_i = 1'b0;
      wait_drain();

      $display("[TB] reset wins over a simultaneous input handshake");
      rst_i      = 1'b1;
      in_valid_i = 1'b1;
      data_i     = vecs[0].pt;
      cur_exp    = vecs[0].exp;
      @(negedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i      = 1'b0;
      in_valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput("reset priority in_ready", BW'(in_ready_o), BW'(1));
      checkOutput("reset priority busy",     BW'(busy_o),     BW'(0));
      checkOutput("reset priority data_o",   data_o,          BW'(0));

      @(posedge clk_i);
      #1;
      checkOutput("scoreboard empty", BW'(sb.size()), BW'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
